// File: rtl/ssd_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_capture_pkg
// Description : Shared constants, FSM encoding and small helpers for the
//               seven-segment bus capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_capture_pkg;

    // Number of multiplexed digits on the display bus (shared with ssd).
    localparam int DIGITS = 4;

    // Width of one digit pattern {dp,g,f,e,d,c,b,a}.
    localparam int SEG_W = 8;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } cap_state_e;

    // Number of set bits in a 4-bit anode vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // Index of the set bit of a one-hot 4-bit anode vector.
    function automatic logic [1:0] onehot_idx4(input logic [3:0] v);
        case (v)
            4'b0010: onehot_idx4 = 2'd1;
            4'b0100: onehot_idx4 = 2'd2;
            4'b1000: onehot_idx4 = 2'd3;
            default: onehot_idx4 = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_sync2.sv
`default_nettype none
// ============================================================================
// Module      : ssd_sync2
// Description : Generic N-bit two-flop synchronizer with a parameterised
//               reset value (synchronous, active-low reset).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_sync2 #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta_q;
    logic [WIDTH-1:0] r_sync_q;

    // Two-stage resynchronisation of the raw bus into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta_q <= RESET_VAL;
            r_sync_q <= RESET_VAL;
        end else begin
            r_meta_q <= i_d;
            r_sync_q <= r_meta_q;
        end
    end

    assign o_q = r_sync_q;

endmodule
`default_nettype wire

// File: rtl/ssd_capture.sv
`default_nettype none
// ============================================================================
// Module      : ssd_capture
// Description : Receive side of the four-digit multiplexed seven-segment
//               bus. Waits for each enabled digit to be stable, rebuilds the
//               four digit patterns (stored lit-high) and reports frame
//               completion, value changes, multi-anode faults and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_capture
    import ssd_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter bit ANODE_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEG_W-1:0]  seven,
    input  logic [DIGITS-1:0] segment,
    output logic [SEG_W-1:0]  disp0,
    output logic [SEG_W-1:0]  disp1,
    output logic [SEG_W-1:0]  disp2,
    output logic [SEG_W-1:0]  disp3,
    output logic [DIGITS-1:0] digit_vld,
    output logic              frame_done,
    output logic              changed,
    output logic              multi_err,
    output logic              stale
);

    localparam int c_BUS_W = DIGITS + SEG_W;
    localparam int c_CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_ONE   = c_TO_W'(1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX   = c_TO_W'(TIMEOUT_CYCLES);

    // Raw-bus value that normalises to "no anode, nothing lit"; the
    // synchronizer resets to it so a reset never looks like bus activity.
    localparam logic [DIGITS-1:0] c_AN_IDLE  = ANODE_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [SEG_W-1:0]  c_SEG_IDLE = SEG_ACT_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [c_BUS_W-1:0] c_SYNC_RST = {c_AN_IDLE, c_SEG_IDLE};

    // ------------------------------------------------------------------
    // Synchronised and normalised bus
    // ------------------------------------------------------------------
    logic [c_BUS_W-1:0] w_sync;
    logic [DIGITS-1:0]  w_an;
    logic [SEG_W-1:0]   w_pat;
    logic [c_BUS_W-1:0] w_bus;
    logic               w_bus_chg;

    ssd_sync2 #(
        .WIDTH     (c_BUS_W),
        .RESET_VAL (c_SYNC_RST)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({segment, seven}),
        .o_q (w_sync)
    );

    assign w_an  = ANODE_ACT_LOW ? ~w_sync[c_BUS_W-1:SEG_W] : w_sync[c_BUS_W-1:SEG_W];
    assign w_pat = SEG_ACT_LOW   ? ~w_sync[SEG_W-1:0]       : w_sync[SEG_W-1:0];
    assign w_bus = {w_an, w_pat};

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    cap_state_e                     r_state_q, w_state_d;
    logic [c_CNT_W-1:0]             r_cnt_q,   w_cnt_d;
    logic [c_BUS_W-1:0]             r_prev_q;
    logic [DIGITS-1:0][SEG_W-1:0]   r_disp_q,  w_disp_d;
    logic [DIGITS-1:0]              r_vld_q,   w_vld_d;
    logic [DIGITS-1:0]              r_mask_q,  w_mask_d;
    logic                           r_frame_q, w_frame_d;
    logic                           r_chg_q,   w_chg_d;
    logic                           r_multi_q, w_multi_d;
    logic [c_TO_W-1:0]              r_to_q,    w_to_d;

    logic                           w_cap_en;
    logic                           w_multi_set;
    logic [1:0]                     w_cap_idx;
    logic [DIGITS-1:0]              w_cap_bit;
    logic [DIGITS-1:0]              w_mask_or;

    assign w_bus_chg = (w_bus != r_prev_q);
    assign w_cap_idx = onehot_idx4(w_an);
    assign w_cap_bit = DIGITS'(1) << w_cap_idx;
    assign w_mask_or = r_mask_q | w_cap_bit;

    // FSM state, settle counter and previous-bus register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= c_CNT_ZERO;
            r_prev_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_prev_q  <= w_bus;
        end
    end

    // Next state: wait for a stable bus, then decide capture / fault / idle.
    // The settle count includes the cycle on which the new value is first
    // seen, so an exit happens after SETTLE_CYCLES unchanged cycles. The
    // anode class is evaluated at exit time: the bus is unchanged across the
    // whole settle window, so it matches the class seen on entry.
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_cap_en    = 1'b0;
        w_multi_set = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_an != '0) begin
                    w_state_d = ST_SETTLE;
                    w_cnt_d   = c_CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (w_bus_chg) begin
                    w_cnt_d = c_CNT_ONE;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d = c_CNT_ZERO;
                    if (w_an == '0) begin
                        w_state_d = ST_IDLE;
                    end else if (popcount4(w_an) == 3'd1) begin
                        w_cap_en  = 1'b1;
                        w_state_d = ST_HOLD;
                    end else begin
                        w_multi_set = 1'b1;
                        w_state_d   = ST_HOLD;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (w_bus_chg) begin
                    w_state_d = ST_SETTLE;
                    w_cnt_d   = c_CNT_ONE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = c_CNT_ZERO;
            end
        endcase
    end

    // Capture datapath: digit store, valid bits, frame mask, pulses, timeout.
    always_comb begin
        w_disp_d  = r_disp_q;
        w_vld_d   = r_vld_q;
        w_mask_d  = r_mask_q;
        w_frame_d = 1'b0;
        w_chg_d   = 1'b0;
        w_multi_d = r_multi_q | w_multi_set;
        w_to_d    = (r_to_q == c_TO_MAX) ? r_to_q : (r_to_q + c_TO_ONE);
        if (w_cap_en) begin
            w_disp_d[w_cap_idx] = w_pat;
            w_vld_d             = r_vld_q | w_cap_bit;
            w_chg_d             = (w_pat != r_disp_q[w_cap_idx]);
            w_to_d              = '0;
            if (w_mask_or == {DIGITS{1'b1}}) begin
                w_frame_d = 1'b1;
                w_mask_d  = '0;
            end else begin
                w_mask_d  = w_mask_or;
            end
        end
    end

    // Registered capture results; a reset drops any partial capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_disp_q  <= '0;
            r_vld_q   <= '0;
            r_mask_q  <= '0;
            r_frame_q <= 1'b0;
            r_chg_q   <= 1'b0;
            r_multi_q <= 1'b0;
            r_to_q    <= '0;
        end else begin
            r_disp_q  <= w_disp_d;
            r_vld_q   <= w_vld_d;
            r_mask_q  <= w_mask_d;
            r_frame_q <= w_frame_d;
            r_chg_q   <= w_chg_d;
            r_multi_q <= w_multi_d;
            r_to_q    <= w_to_d;
        end
    end

    assign disp0      = r_disp_q[0];
    assign disp1      = r_disp_q[1];
    assign disp2      = r_disp_q[2];
    assign disp3      = r_disp_q[3];
    assign digit_vld  = r_vld_q;
    assign frame_done = r_frame_q;
    assign changed    = r_chg_q;
    assign multi_err  = r_multi_q;
    assign stale      = (r_to_q == c_TO_MAX);

endmodule
`default_nettype wire

// File: tb/tb_ssd_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_capture
// Description : Self-checking bench for ssd_capture. Directed bus vectors
//               push hand-computed capture events into a queue; a monitor
//               compares them whenever changed or frame_done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_capture;

    typedef struct packed {
        logic [31:0] disp;   // {disp3,disp2,disp1,disp0}
        logic [3:0]  vld;
        logic        chg;
        logic        fd;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seven;
    logic [3:0] segment;
    logic [7:0] disp0, disp1, disp2, disp3;
    logic [3:0] digit_vld;
    logic       frame_done, changed, multi_err, stale;

    int  n_checks = 0;
    int  n_pass   = 0;
    ev_t exp_q[$];
    ev_t mon_got;
    ev_t mon_exp;

    ssd_capture #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64),
        .ANODE_ACT_LOW  (1'b1),
        .SEG_ACT_LOW    (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seven      (seven),
        .segment    (segment),
        .disp0      (disp0),
        .disp1      (disp1),
        .disp2      (disp2),
        .disp3      (disp3),
        .digit_vld  (digit_vld),
        .frame_done (frame_done),
        .changed    (changed),
        .multi_err  (multi_err),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks = n_checks + 1;
        if (got === want) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] v, input logic c, input logic f);
        ev_t e;
        e.disp = d;
        e.vld  = v;
        e.chg  = c;
        e.fd   = f;
        exp_q.push_back(e);
    endtask

    // Drive one bus value, aligned to the falling edge, for n cycles.
    task automatic drive(input logic [3:0] seg, input logic [7:0] sev, input int n);
        segment = seg;
        seven   = sev;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        seven   = 8'h00;
        segment = 4'h0;

        // Scoreboard monitor: every changed/frame_done pulse consumes one event.
        fork
            forever begin
                @(negedge clk);
                if (rst && (changed || frame_done)) begin
                    mon_got = {disp3, disp2, disp1, disp0, digit_vld, changed, frame_done};
                    if (exp_q.size() == 0) begin
                        n_checks = n_checks + 1;
                        $display("FAIL unexpected_event: got disp=%h vld=%h chg=%b fd=%b, expected no event",
                                 mon_got.disp, mon_got.vld, mon_got.chg, mon_got.fd);
                    end else begin
                        mon_exp  = exp_q.pop_front();
                        n_checks = n_checks + 1;
                        if (mon_got === mon_exp) n_pass = n_pass + 1;
                        else $display("FAIL capture_event: got disp=%h vld=%h chg=%b fd=%b, expected disp=%h vld=%h chg=%b fd=%b",
                                      mon_got.disp, mon_got.vld, mon_got.chg, mon_got.fd,
                                      mon_exp.disp, mon_exp.vld, mon_exp.chg, mon_exp.fd);
                    end
                end
            end
        join_none

        // Reset with random bus activity for three clock edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seven   = 8'($urandom);
            segment = 4'($urandom);
        end
        check("rst_disp",       {disp3, disp2, disp1, disp0}, 64'h0);
        check("rst_digit_vld",  64'(digit_vld), 64'h0);
        check("rst_frame_done", 64'(frame_done), 64'h0);
        check("rst_changed",    64'(changed), 64'h0);
        check("rst_multi_err",  64'(multi_err), 64'h0);
        check("rst_stale",      64'(stale), 64'h0);
        check("rst_fsm_idle",   64'(dut.r_state_q), 64'h0);

        // Timeout: idle bus from release; stale rises on the 64th edge.
        segment = 4'hF;
        seven   = 8'hFF;
        rst     = 1'b1;
        repeat (63) @(posedge clk);
        #1 check("stale_before_64", 64'(stale), 64'h0);
        @(posedge clk);
        #1 check("stale_at_64", 64'(stale), 64'h1);
        @(negedge clk);

        // Clean scan 1: every digit new -> four changed pulses, frame on digit 3.
        push_exp(32'h0000003F, 4'h1, 1'b1, 1'b0);
        drive(4'b1110, 8'hC0, 8);
        push_exp(32'h0000063F, 4'h3, 1'b1, 1'b0);
        drive(4'b1101, 8'hF9, 8);
        push_exp(32'h005B063F, 4'h7, 1'b1, 1'b0);
        drive(4'b1011, 8'hA4, 8);
        push_exp(32'h4F5B063F, 4'hF, 1'b1, 1'b1);
        drive(4'b0111, 8'hB0, 8);
        // Clean scan 2: identical values -> only the frame pulse.
        drive(4'b1110, 8'hC0, 8);
        drive(4'b1101, 8'hF9, 8);
        drive(4'b1011, 8'hA4, 8);
        push_exp(32'h4F5B063F, 4'hF, 1'b0, 1'b1);
        drive(4'b0111, 8'hB0, 8);
        drive(4'hF, 8'hFF, 12);
        drain("scan_drain");
        check("scan_digit_vld", 64'(digit_vld), 64'hF);
        check("scan_stale_clr", 64'(stale), 64'h0);
        check("scan_multi_err", 64'(multi_err), 64'h0);

        // Ghosting: blank pattern for SETTLE_CYCLES-1 cycles is never captured.
        drive(4'b1110, 8'h00, 3);
        push_exp(32'h4F5B066D, 4'hF, 1'b1, 1'b0);
        drive(4'b1110, 8'h92, 8);
        drive(4'hF, 8'hFF, 12);
        drain("ghost_drain");

        // Multi-anode: two digits enabled for 10 cycles -> sticky fault only.
        drive(4'b1100, 8'h00, 10);
        drive(4'hF, 8'hFF, 4);
        check("multi_err_set",  64'(multi_err), 64'h1);
        check("multi_disp",     {disp3, disp2, disp1, disp0}, 64'h4F5B066D);
        drive(4'hF, 8'hFF, 10);
        check("multi_err_sticky", 64'(multi_err), 64'h1);

        // Reset while holding digit 1, with the bus left unchanged.
        push_exp(32'h4F5B666D, 4'hF, 1'b1, 1'b0);
        drive(4'b1101, 8'h99, 10);
        drain("hold_drain");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_disp",      {disp3, disp2, disp1, disp0}, 64'h0);
        check("midrst_digit_vld", 64'(digit_vld), 64'h0);
        check("midrst_multi_err", 64'(multi_err), 64'h0);
        rst = 1'b1;
        push_exp(32'h00006600, 4'h2, 1'b1, 1'b0);
        @(negedge clk);
        check("midrst_no_restore", 64'(disp1), 64'h0);
        repeat (10) @(negedge clk);
        // Mask restarts from digit 1 alone, so the frame closes on digit 0.
        push_exp(32'h005B6600, 4'h6, 1'b1, 1'b0);
        drive(4'b1011, 8'hA4, 8);
        push_exp(32'h4F5B6600, 4'hE, 1'b1, 1'b0);
        drive(4'b0111, 8'hB0, 8);
        push_exp(32'h4F5B663F, 4'hF, 1'b1, 1'b1);
        drive(4'b1110, 8'hC0, 8);
        drive(4'hF, 8'hFF, 12);
        drain("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
